// File: rtl/chg_entry_fetch.sv
// Change-list walker feeding yAddrDecodr: reads each {row,col} entry, fetches the matching
// ySRAM row and presents {row, col, rowData} over a valid/ready handshake.
module chg_entry_fetch #(
   parameter int CHG_AW = 8,
   parameter int Y_AW   = 11,
   parameter int Y_DW   = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CHG_AW:0]   num_chg,
   output logic              chg_rd_en,
   output logic [CHG_AW-1:0] chg_addr,
   input  logic [31:0]       chg_data,
   output logic              ysram_rd_en,
   output logic [Y_AW-1:0]   ysram_addr,
   input  logic [Y_DW-1:0]   ysram_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_row,
   output logic [15:0]       out_col,
   output logic [Y_DW-1:0]   out_rowData,
   output logic              busy,
   output logic              done,
   output logic              err_row,
   output logic [CHG_AW:0]   proc_cnt
);

   typedef enum logic [2:0] {
      IDLE, RD_CHG, CAP_CHG, RD_Y, CAP_Y, PRESENT, FIN
   } state_t;

   localparam logic [CHG_AW:0]   CNT_ONE = 1;
   localparam logic [CHG_AW-1:0] IDX_ONE = 1;

   state_t            state, state_nxt;
   logic [CHG_AW-1:0] idx;
   logic [CHG_AW:0]   num_q;
   logic              last;
   logic              row_term;
   logic              row_oor;

   // last is true while idx points at the final entry of the pass
   assign last     = (({1'b0, idx}) + CNT_ONE) == num_q;
   assign row_term = chg_data[31:16] == 16'hFFFF;
   assign row_oor  = (chg_data[31:16] >> Y_AW) != 16'd0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      chg_rd_en   = 1'b0;
      ysram_rd_en = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_chg == '0) ? FIN : RD_CHG;
         end
         RD_CHG: begin
            busy      = 1'b1;
            chg_rd_en = 1'b1;
            state_nxt = CAP_CHG;
         end
         CAP_CHG: begin
            busy = 1'b1;
            if (row_term)     state_nxt = FIN;
            else if (row_oor) state_nxt = last ? FIN : RD_CHG;
            else              state_nxt = RD_Y;
         end
         RD_Y: begin
            busy        = 1'b1;
            ysram_rd_en = 1'b1;
            state_nxt   = CAP_Y;
         end
         CAP_Y: begin
            busy      = 1'b1;
            state_nxt = PRESENT;
         end
         PRESENT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = last ? FIN : RD_CHG;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign chg_addr   = idx;
   assign ysram_addr = out_row[Y_AW-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx         <= '0;
         num_q       <= '0;
         err_row     <= 1'b0;
         proc_cnt    <= '0;
         out_row     <= '0;
         out_col     <= '0;
         out_rowData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  num_q    <= num_chg;
                  err_row  <= 1'b0;
                  proc_cnt <= '0;
                  idx      <= '0;
               end
            end
            CAP_CHG: begin
               out_row <= chg_data[31:16];
               out_col <= chg_data[15:0];
               if (row_term) begin
                  err_row <= 1'b1;
               end else if (row_oor) begin
                  err_row <= 1'b1;
                  if (!last) idx <= idx + IDX_ONE;
               end
            end
            CAP_Y: out_rowData <= ysram_data;
            PRESENT: begin
               // idx stops at num_chg-1 so a full 256-entry pass ends on 8'hFF
               if (out_ready) begin
                  proc_cnt <= proc_cnt + CNT_ONE;
                  if (!last) idx <= idx + IDX_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chg_entry_fetch.sv
// Bench for chg_entry_fetch: memory models, a scoreboard queue of expected transfers and a
// negedge monitor that compares every presented entry against the queue head.
module tb_chg_entry_fetch;

   localparam int CHG_AW = 8;
   localparam int Y_AW   = 11;
   localparam int Y_DW   = 256;

   typedef struct {
      logic [15:0]     row;
      logic [15:0]     col;
      logic [Y_DW-1:0] data;
   } xfer_t;

   logic              clock, reset, start;
   logic [CHG_AW:0]   num_chg;
   logic              chg_rd_en, ysram_rd_en, out_valid, out_ready;
   logic [CHG_AW-1:0] chg_addr;
   logic [31:0]       chg_data;
   logic [Y_AW-1:0]   ysram_addr;
   logic [Y_DW-1:0]   ysram_data, out_rowData;
   logic [15:0]       out_row, out_col;
   logic              busy, done, err_row;
   logic [CHG_AW:0]   proc_cnt;

   chg_entry_fetch #(.CHG_AW(CHG_AW), .Y_AW(Y_AW), .Y_DW(Y_DW)) dut (
      .clock(clock), .reset(reset), .start(start), .num_chg(num_chg),
      .chg_rd_en(chg_rd_en), .chg_addr(chg_addr), .chg_data(chg_data),
      .ysram_rd_en(ysram_rd_en), .ysram_addr(ysram_addr), .ysram_data(ysram_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
      .out_rowData(out_rowData), .busy(busy), .done(done), .err_row(err_row),
      .proc_cnt(proc_cnt)
   );

   int checks = 0;
   int passes = 0;
   int xfers = 0, done_cnt = 0, chg_reads = 0, y_reads = 0, overlap = 0;
   int rd_hits[256];
   logic [CHG_AW-1:0] last_chg_addr;
   logic [31:0] chg_mem[256];
   xfer_t exp_q[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [Y_DW-1:0] ydata(input logic [Y_AW-1:0] a);
      if (a == 11'd5) return {32{8'hA5}};
      return {8{{5'b0, a}, 16'hBEEF}};
   endfunction

   always @(posedge clock) begin
      if (chg_rd_en)   chg_data   <= chg_mem[chg_addr];
      if (ysram_rd_en) ysram_data <= ydata(ysram_addr);
   end

   task automatic chk(input string name, input logic [Y_DW-1:0] act, input logic [Y_DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clock) begin
      if (reset && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_xfer", 1, 0);
         end else begin
            chk("out_row", out_row, exp_q[0].row);
            chk("out_col", out_col, exp_q[0].col);
            chk("out_rowData", out_rowData, exp_q[0].data);
            if (out_ready) begin
               void'(exp_q.pop_front());
               xfers++;
            end
         end
      end
      if (chg_rd_en && ysram_rd_en) overlap++;
      if (out_valid && (chg_rd_en || ysram_rd_en)) overlap++;
      if (done) done_cnt++;
      if (chg_rd_en) begin
         chg_reads++;
         last_chg_addr = chg_addr;
         rd_hits[chg_addr]++;
      end
      if (ysram_rd_en) y_reads++;
   end

   task automatic push(input logic [15:0] row, input logic [15:0] col);
      xfer_t x;
      x.row  = row;
      x.col  = col;
      x.data = ydata(row[Y_AW-1:0]);
      exp_q.push_back(x);
   endtask

   task automatic do_start(input int n);
      @(posedge clock); #1;
      start   = 1'b1;
      num_chg = n[CHG_AW:0];
      @(posedge clock); #1;
      start   = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (done) break;
         @(posedge clock); #1;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic wait_xfers(input int n, input int bound);
      int i;
      for (i = 0; i < bound && xfers < n; i++) begin
         @(posedge clock); #1;
      end
      chk("xfer_wait", xfers >= n, 1);
   endtask

   task automatic finish_pass(input int d0, input int exp_proc, input logic exp_err);
      @(posedge clock); #1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("done_low", done, 0);
      chk("busy_low", busy, 0);
      chk("proc_cnt", proc_cnt, exp_proc);
      chk("err_row", err_row, exp_err);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      int d0, r0, y0, i;
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, r0, y0;
      reset = 1'b0; start = 1'b0; out_ready = 1'b0; num_chg = '0;
      chg_data = '0; ysram_data = '0;
      for (int i = 0; i < 256; i++) begin chg_mem[i] = '0; rd_hits[i] = 0; end
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", {out_valid, busy, done, err_row, chg_rd_en, ysram_rd_en, proc_cnt,
                             out_row, out_col, chg_addr}, 0);
      chk("reset_rowData", out_rowData, 0);
      reset = 1'b1;

      // 1) single entry, latency and done timing
      chg_mem[0] = {16'd5, 16'd9};
      exp_q.push_back('{16'd5, 16'd9, {32{8'hA5}}});
      out_ready = 1'b1;
      d0 = done_cnt;
      do_start(1);
      chk("busy_after_start", busy, 1);
      repeat (3) begin @(posedge clock); #1; end
      chk("valid_not_early", out_valid, 0);
      @(posedge clock); #1;
      chk("valid_at_5", out_valid, 1);
      @(posedge clock); #1;
      chk("done_after_xfer", done, 1);
      chk("busy_with_done", busy, 0);
      finish_pass(d0, 1, 0);

      // 2) three entries with a 4-cycle stall on the second
      chg_mem[0] = {16'd100, 16'd1};
      chg_mem[1] = {16'd200, 16'd2};
      chg_mem[2] = {16'd2047, 16'd3};
      push(16'd100, 16'd1); push(16'd200, 16'd2); push(16'd2047, 16'd3);
      xfers = 0;
      d0 = done_cnt;
      do_start(3);
      wait_xfers(1, 20);
      out_ready = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clock); #1; end
      chk("stall_valid", out_valid, 1);
      repeat (4) begin @(posedge clock); #1; end
      chk("stall_held_valid", out_valid, 1);
      chk("stall_no_xfer", xfers, 1);
      out_ready = 1'b1;
      wait_done(30);
      finish_pass(d0, 3, 0);

      // 3) out-of-range row skipped; then out-of-range as the final entry
      chg_mem[0] = {16'd10, 16'd1};
      chg_mem[1] = {16'd3000, 16'd2};
      chg_mem[2] = {16'd2047, 16'd7};
      push(16'd10, 16'd1); push(16'd2047, 16'd7);
      d0 = done_cnt;
      do_start(3);
      wait_done(40);
      finish_pass(d0, 2, 1);
      chg_mem[0] = {16'd0, 16'd3};
      chg_mem[1] = {16'd2048, 16'd4};
      push(16'd0, 16'd3);
      d0 = done_cnt;
      do_start(2);
      wait_done(30);
      finish_pass(d0, 1, 1);

      // 4) terminator stops the pass before entry 3 is read
      chg_mem[0] = {16'd1, 16'd1};
      chg_mem[1] = {16'd2, 16'd2};
      chg_mem[2] = {16'hFFFF, 16'd0};
      chg_mem[3] = {16'd4, 16'd4};
      push(16'd1, 16'd1); push(16'd2, 16'd2);
      for (int i = 0; i < 256; i++) rd_hits[i] = 0;
      d0 = done_cnt;
      do_start(4);
      wait_done(40);
      finish_pass(d0, 2, 1);
      chk("no_read_addr3", rd_hits[3], 0);

      // 5) empty pass, then a start pulse while busy
      r0 = chg_reads; y0 = y_reads;
      d0 = done_cnt;
      do_start(0);
      wait_done(2);
      finish_pass(d0, 0, 0);
      chk("empty_no_chg_reads", chg_reads - r0, 0);
      chk("empty_no_y_reads", y_reads - y0, 0);
      chg_mem[0] = {16'd7, 16'd70};
      chg_mem[1] = {16'd8, 16'd80};
      push(16'd7, 16'd70); push(16'd8, 16'd80);
      d0 = done_cnt;
      do_start(2);
      @(posedge clock); #1;
      start = 1'b1; num_chg = 9'd9;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(30);
      finish_pass(d0, 2, 0);

      // full 256-entry pass exercises address wrap
      for (int i = 0; i < 256; i++) begin
         chg_mem[i] = {16'((i * 7) & 2047), 16'(i)};
         push(16'((i * 7) & 2047), 16'(i));
      end
      r0 = chg_reads;
      d0 = done_cnt;
      do_start(256);
      wait_done(1400);
      finish_pass(d0, 256, 0);
      chk("full_reads", chg_reads - r0, 256);
      chk("full_last_addr", last_chg_addr, 8'hFF);

      // 6) reset during PRESENT, then a clean pass from idx 0
      chg_mem[0] = {16'd11, 16'd1};
      chg_mem[1] = {16'd12, 16'd2};
      push(16'd11, 16'd1);
      out_ready = 1'b0;
      d0 = done_cnt;
      do_start(2);
      for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clock); #1; end
      chk("pre_reset_valid", out_valid, 1);
      reset = 1'b0;
      #1;
      chk("abort_outputs", {out_valid, busy, done, err_row, chg_rd_en, ysram_rd_en, proc_cnt,
                            out_row, out_col, chg_addr}, 0);
      chk("abort_rowData", out_rowData, 0);
      exp_q.delete();
      repeat (3) @(posedge clock);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      reset = 1'b1;
      out_ready = 1'b1;
      push(16'd11, 16'd1);
      r0 = chg_reads;
      d0 = done_cnt;
      do_start(1);
      wait_done(20);
      finish_pass(d0, 1, 0);
      chk("restart_one_read", chg_reads - r0, 1);
      chk("restart_addr0", last_chg_addr, 0);

      chk("strobe_exclusive", overlap, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
